// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to TX and RX, and parity types.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver (slave) and the block that drives its line/config (master).
// data_valid, par_err and stp_err are single-cycle pulses with no ready: the consumer must capture that cycle.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  uart_state_t           state;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
    input  P_DATA, data_valid, par_err, stp_err, state
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
    output P_DATA, data_valid, par_err, stp_err, state
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and sample-point logic for the UART receiver.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around mid-bit; otherwise one sample at mid-bit.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_val,
  output logic                  sample_stb,
  output logic                  bit_end,
  output logic                  pre_end
);
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] half;

  assign half    = prescale >> 1;
  assign bit_end = (cnt == prescale - PRESCALE_W'(1));
  // One cycle ahead of bit end, so registered outputs land on the last edge of the bit
  assign pre_end = (cnt == prescale - PRESCALE_W'(2));

  always_ff @(posedge CLK) begin
    if (RST || !run) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s0, s1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (cnt == half - PRESCALE_W'(1)) s0 <= rx;
      if (cnt == half) s1 <= rx;
    end
  end

  assign sample_stb = run && (cnt == half + PRESCALE_W'(1));
  assign bit_val    = (s0 & s1) | (s0 & rx) | (s1 & rx);
`else
  assign sample_stb = run && (cnt == half);
  assign bit_val    = rx;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: frame FSM, deserializer, parity/stop checks and registered outputs.
// Sampling mode selected by UART_RX_MAJORITY_EN inside uart_rx_sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave bus
);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_t           state, next_state;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  start_bad, par_bad, stp_bad;
  logic                  par_en_q, par_typ_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  start_det, run, last_bit, exp_par;
  logic                  bit_val, sample_stb, bit_end, pre_end;

  assign start_det = (state == IDLE) && !bus.RX_IN;
  assign run       = (state != IDLE) || start_det;
  assign last_bit  = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign exp_par   = (par_typ_q == ODD) ? ~^shreg : ^shreg;
  assign bus.state = state;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .run        (run),
    .rx         (bus.RX_IN),
    .prescale   (presc_q),
    .bit_val    (bit_val),
    .sample_stb (sample_stb),
    .bit_end    (bit_end),
    .pre_end    (pre_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_det) next_state = START;
      START:   if (bit_end) next_state = start_bad ? IDLE : DATA;
      DATA:    if (bit_end && last_bit) next_state = par_en_q ? PAR : STOP;
      PAR:     if (bit_end) next_state = STOP;
      STOP:    if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt        <= '0;
      shreg          <= '0;
      start_bad      <= 1'b0;
      par_bad        <= 1'b0;
      stp_bad        <= 1'b0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      presc_q        <= '0;
      bus.P_DATA     <= '0;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
      // Frame configuration is frozen at start detect
      if (start_det) begin
        presc_q   <= bus.PRESCALE;
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        bit_cnt   <= '0;
        start_bad <= 1'b0;
        par_bad   <= 1'b0;
        stp_bad   <= 1'b0;
      end
      if (sample_stb) begin
        case (state)
          START:   start_bad <= bit_val;
          DATA:    shreg     <= {bit_val, shreg[DATA_WIDTH-1:1]};
          PAR:     par_bad   <= (bit_val != exp_par);
          STOP:    stp_bad   <= !bit_val;
          default: ;
        endcase
      end
      if (state == DATA && bit_end) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (state == STOP && pre_end) begin
        if (!par_bad && !stp_bad) begin
          bus.P_DATA     <= shreg;
          bus.data_valid <= 1'b1;
        end else begin
          bus.par_err <= par_bad;
          bus.stp_err <= stp_bad;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames, scoreboards pulse type, word and pulse cycle.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int W  = 8;
  localparam int PW = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_rx_if #(.DATA_WIDTH(W), .PRESCALE_W(PW)) bus ();

  uart_rx #(.DATA_WIDTH(W), .PRESCALE_W(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // clock
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // scoreboard entry: {par_err, stp_err, P_DATA}; data_valid expected when both flags are 0
  logic [W+1:0]  exp_q[$];
  int            exp_cyc_q[$];
  logic [W-1:0]  last_good = '0;
  logic [W+1:0]  mon_e;
  int            mon_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: cyc counts negedges; every pulse must match the head of the scoreboard
  always @(negedge CLK) begin
    cyc++;
    if (bus.data_valid || bus.par_err || bus.stp_err) begin
      if (exp_q.size() == 0) begin
        check("stray_pulse", {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("flags", {29'd0, bus.data_valid, bus.par_err, bus.stp_err},
              {29'd0, (mon_e[W+1:W] == 2'b00), mon_e[W+1:W]});
        check("p_data", 32'(bus.P_DATA), 32'(mon_e[W-1:0]));
        check("pulse_cycle", mon_c, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_reset(input int n);
    RST = 1'b1;
    tick(n);
    RST = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int p, input int gc);
    for (int c = 0; c < p; c++) begin
      bus.RX_IN = (c == gc) ? ~b : b;
      tick(1);
    end
  endtask

  // Drive one frame starting now (just after a posedge). flip corrupts parity, stop_bit is the
  // stop level, glitch_bit/glitch_cyc invert one cycle of a data bit, abort_bit resets mid-bit.
  task automatic send_frame(input logic [W-1:0] d, input int p, input logic pe, input logic pt,
                            input logic flip, input logic stop_bit,
                            input int glitch_bit, input int glitch_cyc, input int abort_bit);
    int   n;
    logic pb;
    n  = 2 + W + int'(pe);
    pb = ((pt == ODD) ? ~^d : ^d) ^ flip;
    bus.PRESCALE = PW'(p);
    bus.PAR_EN   = pe;
    bus.PAR_TYP  = pt;
    if (abort_bit < 0) begin
      if (!flip && stop_bit) last_good = d;
      exp_q.push_back({(pe & flip), ~stop_bit, last_good});
      exp_cyc_q.push_back(cyc + 1 + n * p - 1);
    end
    drive_bit(1'b0, p, -1);
    // config ports wander mid-frame; the receiver must ignore them
    bus.PRESCALE = PW'((p == 8) ? 16 : 8);
    bus.PAR_EN   = ~pe;
    bus.PAR_TYP  = ~pt;
    for (int i = 0; i < W; i++) begin
      if (i == abort_bit) begin
        drive_bit(d[i], p / 2, -1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        bus.RX_IN = 1'b1;
        last_good = '0;
        return;
      end
      drive_bit(d[i], p, (i == glitch_bit) ? glitch_cyc : -1);
    end
    if (pe) drive_bit(pb, p, -1);
    drive_bit(stop_bit, p, -1);
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = EVEN;
    bus.PRESCALE = PW'(8);
    apply_reset(3);

    check("rst_p_data", 32'(bus.P_DATA), 32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_par_err", 32'(bus.par_err), 32'd0);
    check("rst_stp_err", 32'(bus.stp_err), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));

    // basic frame, then even parity good / bad
    send_frame(8'hA5, 8, 1'b0, EVEN, 1'b0, 1'b1, -1, -1, -1);
    tick(5);
    send_frame(8'h3C, 16, 1'b1, EVEN, 1'b0, 1'b1, -1, -1, -1);
    tick(4);
    send_frame(8'h3C, 16, 1'b1, EVEN, 1'b1, 1'b1, -1, -1, -1);
    tick(4);

    // stop error, then the next frame must still be accepted
    send_frame(8'h55, 8, 1'b0, EVEN, 1'b0, 1'b0, -1, -1, -1);
    tick(3);
    send_frame(8'h96, 8, 1'b0, EVEN, 1'b0, 1'b1, -1, -1, -1);
    tick(3);

    // short start glitch: no pulse, back to IDLE
    bus.PRESCALE = PW'(8);
    bus.RX_IN = 1'b0;
    tick(3);
    bus.RX_IN = 1'b1;
    tick(12);
    check("glitch_idle", 32'(bus.state), 32'(IDLE));

    // back-to-back frames, no idle gap
    send_frame(8'h01, 8, 1'b0, EVEN, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'hFF, 8, 1'b0, EVEN, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'h6B, 12, 1'b1, ODD, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'h00, 12, 1'b1, ODD, 1'b1, 1'b0, -1, -1, -1);
    tick(4);

    // line changes away from the sample window are ignored
    send_frame(8'hC3, 16, 1'b0, EVEN, 1'b0, 1'b1, 2, 1, -1);
    send_frame(8'h5C, 16, 1'b0, EVEN, 1'b0, 1'b1, 5, 13, -1);
    tick(4);

    // reset in the middle of data bit 4
    send_frame(8'hE7, 8, 1'b0, EVEN, 1'b0, 1'b1, -1, -1, 4);
    tick(2);
    check("abort_state", 32'(bus.state), 32'(IDLE));
    tick(20);
    check("abort_p_data", 32'(bus.P_DATA), 32'd0);
    send_frame(8'h81, 8, 1'b0, EVEN, 1'b0, 1'b1, -1, -1, -1);
    tick(3);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h4D, 16, 1'b0, EVEN, 1'b0, 1'b1, 3, 8, -1);
    send_frame(8'hB2, 8, 1'b1, EVEN, 1'b0, 1'b1, 6, 4, -1);
    tick(3);
`endif

    for (int k = 0; k < 8; k++) begin
      send_frame(W'($urandom_range(0, 255)), 2 * $urandom_range(4, 16),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) != 0),
                 -1, -1, -1);
      tick($urandom_range(0, 3));
    end

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick(1);
    check("drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
